// File: rtl/rgb2yuv_pkg.sv
// Shared constants, state encoding and the scale/clamp helper for the
// time-shared RGB->YUV332 converter.
package rgb2yuv_pkg;

    localparam int Q       = 7;   // coefficient fraction bits (value/128)
    localparam int N_STEPS = 9;   // products per pixel
    localparam int ACC_W   = 20;  // signed accumulator width

    // Signed Q7 coefficients in step order: Y(R,G,B), U(R,G,B), V(R,G,B).
    localparam logic signed [17:0] COEF [0:8] = '{
        18'sd38,  18'sd75,  18'sd15,
        -18'sd22, -18'sd42, 18'sd64,
        18'sd64,  -18'sd54, -18'sd10
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        DRAIN = 2'd2,
        PACK  = 2'd3
    } state_e;

    // Drop the fraction (floor), optionally re-centre chroma by +512, clamp to 10 bits.
    function automatic logic [9:0] scale_clamp(input logic signed [ACC_W-1:0] acc,
                                               input logic add_offset);
        logic signed [ACC_W-1:0] v;
        logic [9:0]              r;
        v = (acc >>> Q) + (add_offset ? 20'sd512 : 20'sd0);
        if (v < 20'sd0) begin
            r = 10'd0;
        end else if (v > 20'sd1023) begin
            r = 10'd1023;
        end else begin
            r = v[9:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rgb2yuv_seq_mult.sv
// Registered 18x18 signed multiplier with a fixed one-cycle latency.
// Ports: clk, reset_n (async active-low), a/b signed operands, p registered product.
module mult18_reg (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] a,
    input  logic [17:0] b,
    output logic [35:0] p
);

    logic [35:0] p_d;
    logic [35:0] p_q;

    // Full-precision signed product of the current operands.
    always_comb begin
        p_d = 36'($signed(a) * $signed(b));
    end

    // Product register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q <= 36'd0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/rgb2yuv_seq.sv
// Sequenced RGB->YUV332 converter sharing one registered multiplier across the
// nine coefficient products of a pixel; one pixel per 11 clocks.
// Ports: clk, reset_n (async active-low), rgb30/wr_en_i pixel input,
// ready_o acceptance flag, yuv332/wr_en_o result strobe, overflow_o sticky drop flag.
module rgb2yuv_seq
    import rgb2yuv_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] rgb30,
    input  logic        wr_en_i,
    output logic        ready_o,
    output logic [7:0]  yuv332,
    output logic        wr_en_o,
    output logic        overflow_o
);

    state_e                  state_q, state_d;
    logic [3:0]              step_q, step_d;
    logic [29:0]             pix_q, pix_d;
    logic signed [ACC_W-1:0] acc_y_q, acc_y_d, acc_u_q, acc_u_d, acc_v_q, acc_v_d;
    logic                    tag_vld_q, tag_vld_d;
    logic [1:0]              tag_ch_q, tag_ch_d;
    logic [7:0]              yuv_q, yuv_d;
    logic                    wr_en_q, wr_en_d;
    logic                    ovf_q, ovf_d;
    logic                    ready_q, ready_d;

    logic                    accept_s;
    logic [1:0]              ch_s;
    logic [17:0]             a_s;
    logic [17:0]             b_s;
    logic [35:0]             p_s;
    logic signed [ACC_W-1:0] prod_s;
    logic [9:0]              y_s, u_s, v_s;

    mult18_reg u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a_s),
        .b       (b_s),
        .p       (p_s)
    );

    // Operand selection for the current step: channel = step/3, component = step%3.
    always_comb begin
        ch_s = 2'd0;
        a_s  = 18'd0;
        b_s  = 18'd0;
        case (step_q)
            4'd0: begin ch_s = 2'd0; a_s = {8'b0, pix_q[29:20]}; b_s = COEF[0]; end
            4'd1: begin ch_s = 2'd0; a_s = {8'b0, pix_q[19:10]}; b_s = COEF[1]; end
            4'd2: begin ch_s = 2'd0; a_s = {8'b0, pix_q[9:0]};   b_s = COEF[2]; end
            4'd3: begin ch_s = 2'd1; a_s = {8'b0, pix_q[29:20]}; b_s = COEF[3]; end
            4'd4: begin ch_s = 2'd1; a_s = {8'b0, pix_q[19:10]}; b_s = COEF[4]; end
            4'd5: begin ch_s = 2'd1; a_s = {8'b0, pix_q[9:0]};   b_s = COEF[5]; end
            4'd6: begin ch_s = 2'd2; a_s = {8'b0, pix_q[29:20]}; b_s = COEF[6]; end
            4'd7: begin ch_s = 2'd2; a_s = {8'b0, pix_q[19:10]}; b_s = COEF[7]; end
            4'd8: begin ch_s = 2'd2; a_s = {8'b0, pix_q[9:0]};   b_s = COEF[8]; end
            default: begin ch_s = 2'd0; a_s = 18'd0; b_s = 18'd0; end
        endcase
    end

    // Next-state, accumulation and output formation.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        pix_d     = pix_q;
        acc_y_d   = acc_y_q;
        acc_u_d   = acc_u_q;
        acc_v_d   = acc_v_q;
        yuv_d     = yuv_q;
        wr_en_d   = 1'b0;
        ovf_d     = ovf_q;
        tag_vld_d = (state_q == MUL);
        tag_ch_d  = ch_s;
        accept_s  = wr_en_i & ready_q;
        prod_s    = $signed(p_s[ACC_W-1:0]);
        y_s       = scale_clamp(acc_y_q, 1'b0);
        u_s       = scale_clamp(acc_u_q, 1'b1);
        v_s       = scale_clamp(acc_v_q, 1'b1);

        // A strobe while busy is dropped; the in-flight pixel is untouched.
        if (wr_en_i && !ready_q) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        // Product registered last cycle lands in its channel one cycle after issue.
        if (tag_vld_q) begin
            case (tag_ch_q)
                2'd0:    acc_y_d = acc_y_q + prod_s;
                2'd1:    acc_u_d = acc_u_q + prod_s;
                2'd2:    acc_v_d = acc_v_q + prod_s;
                default: acc_y_d = acc_y_q;
            endcase
        end else begin
            acc_y_d = acc_y_q;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (step_q == 4'd8) begin
                    state_d = DRAIN;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            DRAIN: begin
                state_d = PACK;
            end
            PACK: begin
                yuv_d   = {y_s[9:7], u_s[9:7], v_s[9:8]};
                wr_en_d = 1'b1;
                // Accepting here keeps the sustained rate at one pixel per 11 clocks.
                if (accept_s) begin
                    state_d = MUL;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept_s) begin
            pix_d   = rgb30;
            step_d  = 4'd0;
            acc_y_d = '0;
            acc_u_d = '0;
            acc_v_d = '0;
        end else begin
            pix_d = pix_q;
        end

        ready_d = (state_d == IDLE) || (state_d == PACK);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            step_q    <= 4'd0;
            pix_q     <= 30'd0;
            acc_y_q   <= '0;
            acc_u_q   <= '0;
            acc_v_q   <= '0;
            tag_vld_q <= 1'b0;
            tag_ch_q  <= 2'd0;
            yuv_q     <= 8'd0;
            wr_en_q   <= 1'b0;
            ovf_q     <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            pix_q     <= pix_d;
            acc_y_q   <= acc_y_d;
            acc_u_q   <= acc_u_d;
            acc_v_q   <= acc_v_d;
            tag_vld_q <= tag_vld_d;
            tag_ch_q  <= tag_ch_d;
            yuv_q     <= yuv_d;
            wr_en_q   <= wr_en_d;
            ovf_q     <= ovf_d;
            ready_q   <= ready_d;
        end
    end

    assign ready_o    = ready_q;
    assign yuv332     = yuv_q;
    assign wr_en_o    = wr_en_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_rgb2yuv_seq.sv
// Directed and randomized bench for rgb2yuv_seq with an arithmetic reference model.
module tb_rgb2yuv_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] rgb30 = 30'd0;
    logic        wr_en_i = 1'b0;
    logic        ready_o;
    logic [7:0]  yuv332;
    logic        wr_en_o;
    logic        overflow_o;

    int n_cmp  = 0;
    int n_fail = 0;

    rgb2yuv_seq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rgb30      (rgb30),
        .wr_en_i    (wr_en_i),
        .ready_o    (ready_o),
        .yuv332     (yuv332),
        .wr_en_o    (wr_en_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp10(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    // Reference: Q7 weighted sums, floor division by 128, chroma offset, clamp, pack.
    function automatic logic [7:0] ref_yuv(input logic [29:0] px);
        int r, g, b;
        logic [9:0] yy, uu, vv;
        r  = int'(px[29:20]);
        g  = int'(px[19:10]);
        b  = int'(px[9:0]);
        yy = 10'(clamp10((38 * r + 75 * g + 15 * b) >>> 7));
        uu = 10'(clamp10(((-22 * r - 42 * g + 64 * b) >>> 7) + 512));
        vv = 10'(clamp10(((64 * r - 54 * g - 10 * b) >>> 7) + 512));
        return {yy[9:7], uu[9:7], vv[9:8]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel at the accept edge, then find the result strobe within a bound.
    task automatic wait_result(input string tag, input logic [7:0] exp);
        int lat;
        lat = 0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if (wr_en_o) lat = k;
        end
        check({tag, "_latency"}, lat, 11);
        check({tag, "_yuv"}, yuv332, exp);
    endtask

    task automatic send_check(input string tag, input logic [29:0] px);
        logic [7:0] exp;
        exp = ref_yuv(px);
        rgb30   = px;
        wr_en_i = 1'b1;
        check({tag, "_ready"}, ready_o, 1'b1);
        tick();
        wr_en_i = 1'b0;
        wait_result(tag, exp);
        check({tag, "_ready_in_strobe"}, ready_o, 1'b1);
        tick();
        check({tag, "_strobe_one_cycle"}, wr_en_o, 1'b0);
        check({tag, "_yuv_held"}, yuv332, exp);
    endtask

    initial begin
        logic [29:0] pa, pb, pc;
        int pulses;

        // Reset state.
        #12;
        check("rst_yuv", yuv332, 8'h00);
        check("rst_wr_en", wr_en_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        check("rst_ready", ready_o, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();

        // Corner colours, with hand-derived constants alongside the model.
        check("model_white", ref_yuv({10'd1023, 10'd1023, 10'd1023}), 8'hF2);
        send_check("white", {10'd1023, 10'd1023, 10'd1023});
        send_check("black", 30'd0);
        check("black_const", yuv332, 8'h12);
        send_check("red", {10'd1023, 10'd0, 10'd0});
        check("red_const", yuv332, 8'h4B);
        send_check("blue", {10'd0, 10'd0, 10'd1023});
        check("blue_const", yuv332, 8'h1D);
        send_check("green", {10'd0, 10'd1023, 10'd0});

        // Random pixels.
        for (int i = 0; i < 10; i++) begin
            pa = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                  10'($urandom_range(0, 1023))};
            send_check($sformatf("rand%0d", i), pa);
        end

        // Back-to-back: accept at E0, drop at E0+3, accept again at E0+11.
        pa = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
        pb = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
        pc = ~pa;
        rgb30 = pa; wr_en_i = 1'b1;
        tick();                                   // E0
        wr_en_i = 1'b0;
        check("b2b_busy", ready_o, 1'b0);
        check("b2b_ovf_before_drop", overflow_o, 1'b0);
        tick(); tick();                           // after E0+2
        rgb30 = pc; wr_en_i = 1'b1;
        tick();                                   // E0+3, dropped
        wr_en_i = 1'b0; rgb30 = 30'd0;
        tick();                                   // after E0+4
        check("b2b_ovf_set", overflow_o, 1'b1);
        repeat (6) tick();                        // after E0+10
        check("b2b_no_early_strobe", wr_en_o, 1'b0);
        check("b2b_ready_for_second", ready_o, 1'b1);
        rgb30 = pb; wr_en_i = 1'b1;
        tick();                                   // E0+11
        wr_en_i = 1'b0;
        check("b2b_first_strobe", wr_en_o, 1'b1);
        check("b2b_first_yuv", yuv332, ref_yuv(pa));
        wait_result("b2b_second", ref_yuv(pb));
        check("b2b_ovf_sticky", overflow_o, 1'b1);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (wr_en_o) pulses++;
        end
        check("b2b_no_extra_strobe", pulses, 0);
        check("b2b_ovf_still", overflow_o, 1'b1);

        // Reset asserted mid-MUL discards the in-flight pixel.
        rgb30 = {10'd1023, 10'd1023, 10'd1023}; wr_en_i = 1'b1;
        tick();
        wr_en_i = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        check("midrst_yuv", yuv332, 8'h00);
        check("midrst_wr_en", wr_en_o, 1'b0);
        check("midrst_ovf", overflow_o, 1'b0);
        check("midrst_ready", ready_o, 1'b1);
        tick(); tick();
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (wr_en_o) pulses++;
        end
        check("midrst_no_strobe", pulses, 0);
        check("midrst_ready_after", ready_o, 1'b1);
        send_check("after_rst", {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                                 10'($urandom_range(0, 1023))});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
